// File: rtl/execute_store_queue_if.sv
// Pipeline-side and memory-side signals of the store queue.
// slave  : the store queue itself.
// master : whoever drives instructions, the memory port and the load hazard probe.
interface execute_store_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [6:0]          decode_opcode;
    logic [2:0]          decode_funct3;
    logic [ADDR_W-1:0]   decode_imm;
    logic [ADDR_W-1:0]   read_rs1_val;
    logic [DATA_W-1:0]   read_rs2_val;
    logic                read_valid;
    logic                processing;
    logic                valid;
    logic [5:0]          exception_num_out;
    logic                exception_valid_out;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic [DATA_W/8-1:0] mem_strb;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   hazard_addr;
    logic                hazard_hit;
    logic [CNT_W-1:0]    count;
    logic                empty;

    modport slave (
        input  decode_opcode, decode_funct3, decode_imm, read_rs1_val, read_rs2_val,
               read_valid, mem_ready, hazard_addr,
        output processing, valid, exception_num_out, exception_valid_out,
               mem_addr, mem_data, mem_strb, mem_valid, hazard_hit, count, empty
    );

    modport master (
        output decode_opcode, decode_funct3, decode_imm, read_rs1_val, read_rs2_val,
               read_valid, mem_ready, hazard_addr,
        input  processing, valid, exception_num_out, exception_valid_out,
               mem_addr, mem_data, mem_strb, mem_valid, hazard_hit, count, empty
    );
endinterface

// File: rtl/execute_store_queue.sv
// Store execute stage with an in-order store buffer.
// Decodes SB/SH/SW(/SD), forms the effective address, flags misaligned
// stores, lane-positions data and strobes, buffers up to DEPTH stores and
// drains them over a valid/ready memory port. Loads can probe the buffer for
// a pending store to the same aligned word.
module execute_store_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic reset_n,
    execute_store_queue_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0]        OP_STORE = 7'b0100011;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(NB - 1);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [NB-1:0]     ent_strb [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] eff_addr;
    logic [OFF_W-1:0]  off;
    logic              known;
    logic              misaligned;
    logic [DATA_W-1:0] size_mask;
    logic [NB-1:0]     strb_base;
    logic [DATA_W-1:0] lane_data;
    logic [NB-1:0]     lane_strb;
    logic              full;
    logic              is_empty;
    logic              enq;
    logic              deq;
    logic              hit;

    assign eff_addr = bus.read_rs1_val + bus.decode_imm;
    assign off      = eff_addr[OFF_W-1:0];

    // Decode the access size; SD only exists on a 64-bit datapath.
    always_comb begin
        known      = 1'b0;
        misaligned = 1'b0;
        size_mask  = '0;
        strb_base  = '0;
        if (bus.decode_opcode == OP_STORE) begin
            case (bus.decode_funct3)
                3'b000: begin
                    known          = 1'b1;
                    size_mask[7:0] = '1;
                    strb_base[0]   = 1'b1;
                end
                3'b001: begin
                    known           = 1'b1;
                    misaligned      = eff_addr[0];
                    size_mask[15:0] = '1;
                    strb_base[1:0]  = '1;
                end
                3'b010: begin
                    known           = 1'b1;
                    misaligned      = |eff_addr[1:0];
                    size_mask[31:0] = '1;
                    strb_base[3:0]  = '1;
                end
                3'b011: begin
                    known      = (DATA_W == 64);
                    misaligned = |eff_addr[2:0];
                    size_mask  = '1;
                    strb_base  = '1;
                end
                default: ;
            endcase
        end
    end

    assign lane_data = (bus.read_rs2_val & size_mask) << {off, 3'b000};
    assign lane_strb = strb_base << off;

    // Fullness comes from the registered count only: a dequeue this cycle
    // does not free a slot for an enqueue until the next cycle.
    assign full     = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);
    assign enq      = bus.processing && !misaligned && !full;
    assign deq      = !is_empty && bus.mem_ready;

    assign bus.processing          = bus.read_valid && known;
    assign bus.valid               = bus.processing && (misaligned || !full);
    assign bus.exception_valid_out = bus.processing && misaligned;
    assign bus.exception_num_out   = 6'd6;

    assign bus.mem_valid = !is_empty;
    assign bus.mem_addr  = is_empty ? '0 : ent_addr[rd_ptr];
    assign bus.mem_data  = is_empty ? '0 : ent_data[rd_ptr];
    assign bus.mem_strb  = is_empty ? '0 : ent_strb[rd_ptr];
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.hazard_hit = hit;

    // Hazard probe against buffered stores only (not the one being written).
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == (bus.hazard_addr & ~LOW_MASK))) begin
                hit = 1'b1;
            end
        end
    end

    // Buffer write/read pointers, occupancy and entry payloads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
        end else begin
            if (enq) begin
                ent_addr[wr_ptr] <= {eff_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                ent_data[wr_ptr] <= lane_data;
                ent_strb[wr_ptr] <= lane_strb;
                ent_vld[wr_ptr]  <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (deq) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_store_queue.sv
// Bench for execute_store_queue: directed scenarios plus randomized traffic
// compared against a queue-based model of the store buffer.
module tb_execute_store_queue;
    localparam logic [6:0] OPS = 7'b0100011;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    ent_t q32[$];
    ent_t q64[$];

    always #5 clk = ~clk;

    execute_store_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) if32();
    execute_store_queue_if #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) if64();

    execute_store_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut32 (
        .clk(clk), .reset_n(reset_n), .bus(if32));
    execute_store_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .reset_n(reset_n), .bus(if64));

    function automatic bit m_known(logic [6:0] opc, logic [2:0] f3, int dw);
        return (opc == OPS) && ((f3 <= 3'd2) || (f3 == 3'd3 && dw == 64));
    endfunction

    function automatic bit m_mis(logic [2:0] f3, logic [31:0] a);
        int sb;
        sb = 1 << f3;
        return (a % sb) != 0;
    endfunction

    function automatic ent_t m_entry(int dw, logic [2:0] f3, logic [31:0] a, logic [63:0] rs2);
        ent_t e;
        int nb, sb, off;
        logic [63:0] m;
        nb = dw / 8;
        sb = 1 << f3;
        off = int'(a % nb);
        e.addr = a - off;
        m = (sb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sb)) - 64'd1);
        e.data = (rs2 & m) << (8 * off);
        e.strb = 8'(((1 << sb) - 1) << off);
        return e;
    endfunction

    task automatic drive32(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic rv,
                           input logic rdy, input logic [31:0] haz);
        if32.decode_opcode = opc;
        if32.decode_funct3 = f3;
        if32.decode_imm    = imm;
        if32.read_rs1_val  = rs1;
        if32.read_rs2_val  = rs2;
        if32.read_valid    = rv;
        if32.mem_ready     = rdy;
        if32.hazard_addr   = haz;
        #1;
    endtask

    task automatic drive64(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] imm,
                           input logic [31:0] rs1, input logic [63:0] rs2, input logic rv,
                           input logic rdy, input logic [31:0] haz);
        if64.decode_opcode = opc;
        if64.decode_funct3 = f3;
        if64.decode_imm    = imm;
        if64.read_rs1_val  = rs1;
        if64.read_rs2_val  = rs2;
        if64.read_valid    = rv;
        if64.mem_ready     = rdy;
        if64.hazard_addr   = haz;
        #1;
    endtask

    // Advance one clock and move the reference model by the same edge.
    task automatic commit();
        logic [31:0] a32, a64;
        bit e32, d32, e64, d64;
        a32 = if32.read_rs1_val + if32.decode_imm;
        a64 = if64.read_rs1_val + if64.decode_imm;
        e32 = if32.read_valid && m_known(if32.decode_opcode, if32.decode_funct3, 32) &&
              !m_mis(if32.decode_funct3, a32) && (q32.size() < 4);
        d32 = (q32.size() > 0) && if32.mem_ready;
        e64 = if64.read_valid && m_known(if64.decode_opcode, if64.decode_funct3, 64) &&
              !m_mis(if64.decode_funct3, a64) && (q64.size() < 4);
        d64 = (q64.size() > 0) && if64.mem_ready;
        @(posedge clk);
        if (!reset_n) begin
            q32.delete();
            q64.delete();
        end else begin
            if (d32) void'(q32.pop_front());
            if (e32) q32.push_back(m_entry(32, if32.decode_funct3, a32, {32'd0, if32.read_rs2_val}));
            if (d64) void'(q64.pop_front());
            if (e64) q64.push_back(m_entry(64, if64.decode_funct3, a64, if64.read_rs2_val));
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
        drive64(7'd0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b1, 32'd0);
        commit();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive64(7'd0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 32'd0);
        commit();
        commit();
        total++; if (if32.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b exp=0", if32.mem_valid); end
        total++; if (if32.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", if32.empty); end
        total++; if (if32.count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", if32.count); end
        total++; if (if32.hazard_hit !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%b exp=0", if32.hazard_hit); end
        total++; if ({if32.mem_addr, if32.mem_data, if32.mem_strb} !== 68'd0) begin
            bad++; $display("FAIL rst_mem_bus got=%h/%h/%h exp=0", if32.mem_addr, if32.mem_data, if32.mem_strb); end
        total++; if (if64.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid64 got=%b exp=0", if64.mem_valid); end
        reset_n = 1'b1;
    endtask

    task automatic test_sb();
        drive32(OPS, 3'b000, 32'h3, 32'h1000, 32'hAABBCCDD, 1'b1, 1'b0, 32'd0);
        total++; if ({if32.processing, if32.valid, if32.exception_valid_out} !== 3'b110) begin
            bad++; $display("FAIL sb_flags got=%b exp=110", {if32.processing, if32.valid, if32.exception_valid_out}); end
        total++; if (if32.mem_valid !== 1'b0) begin bad++; $display("FAIL sb_latency got=%b exp=0", if32.mem_valid); end
        commit();
        total++; if (if32.mem_valid !== 1'b1) begin bad++; $display("FAIL sb_mem_valid got=%b exp=1", if32.mem_valid); end
        total++; if (if32.mem_addr !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", if32.mem_addr); end
        total++; if (if32.mem_data !== 32'hDD000000) begin bad++; $display("FAIL sb_data got=%h exp=dd000000", if32.mem_data); end
        total++; if (if32.mem_strb !== 4'b1000) begin bad++; $display("FAIL sb_strb got=%b exp=1000", if32.mem_strb); end
        total++; if (if32.count !== 3'd1) begin bad++; $display("FAIL sb_count got=%0d exp=1", if32.count); end
    endtask

    task automatic test_misaligned();
        do_reset();
        drive32(OPS, 3'b001, 32'h1, 32'h1000, 32'hAABBCCDD, 1'b1, 1'b0, 32'd0);
        total++; if (if32.exception_valid_out !== 1'b1) begin bad++; $display("FAIL sh_mis_exc got=%b exp=1", if32.exception_valid_out); end
        total++; if (if32.exception_num_out !== 6'd6) begin bad++; $display("FAIL sh_mis_num got=%0d exp=6", if32.exception_num_out); end
        total++; if (if32.valid !== 1'b1) begin bad++; $display("FAIL sh_mis_valid got=%b exp=1", if32.valid); end
        commit();
        total++; if ({if32.count, if32.mem_valid} !== 4'd0) begin
            bad++; $display("FAIL sh_mis_noenq got=%0d/%b exp=0/0", if32.count, if32.mem_valid); end
        drive32(OPS, 3'b010, 32'h2, 32'h1000, 32'h12345678, 1'b1, 1'b0, 32'd0);
        total++; if (if32.exception_valid_out !== 1'b1) begin bad++; $display("FAIL sw_mis_exc got=%b exp=1", if32.exception_valid_out); end
        commit();
        drive32(OPS, 3'b001, 32'h2, 32'h1000, 32'hAABBCCDD, 1'b1, 1'b0, 32'd0);
        total++; if (if32.exception_valid_out !== 1'b0) begin bad++; $display("FAIL sh_ok_exc got=%b exp=0", if32.exception_valid_out); end
        commit();
        total++; if ({if32.mem_data, if32.mem_strb} !== {32'hCCDD0000, 4'b1100}) begin
            bad++; $display("FAIL sh_ok_lane got=%h/%b exp=ccdd0000/1100", if32.mem_data, if32.mem_strb); end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive32(OPS, 3'b010, 32'd0, 32'h2000 + 32'(4 * i), 32'h11110000 + 32'(i), 1'b1, 1'b0, 32'd0);
            total++; if (if32.valid !== (i < 4)) begin bad++; $display("FAIL fill_valid[%0d] got=%b exp=%b", i, if32.valid, (i < 4)); end
            commit();
        end
        total++; if (if32.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", if32.count); end
        drive32(OPS, 3'b010, 32'd0, 32'h2010, 32'h11110004, 1'b1, 1'b1, 32'd0);
        total++; if (if32.valid !== 1'b0) begin bad++; $display("FAIL full_deq_nobypass got=%b exp=0", if32.valid); end
        total++; if (if32.mem_addr !== 32'h2000) begin bad++; $display("FAIL full_head got=%h exp=00002000", if32.mem_addr); end
        commit();
        total++; if ({if32.count, if32.mem_addr} !== {3'd3, 32'h2004}) begin
            bad++; $display("FAIL after_deq got=%0d/%h exp=3/00002004", if32.count, if32.mem_addr); end
        drive32(OPS, 3'b010, 32'd0, 32'h2010, 32'h11110004, 1'b1, 1'b0, 32'd0);
        total++; if (if32.valid !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", if32.valid); end
        commit();
        for (int j = 1; j < 5; j++) begin
            drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
            total++; if ({if32.mem_addr, if32.mem_data} !== {32'h2000 + 32'(4 * j), 32'h11110000 + 32'(j)}) begin
                bad++; $display("FAIL wrap_order[%0d] got=%h/%h exp=%h/%h", j, if32.mem_addr, if32.mem_data,
                                32'h2000 + 32'(4 * j), 32'h11110000 + 32'(j)); end
            commit();
        end
        total++; if (if32.empty !== 1'b1) begin bad++; $display("FAIL drained_empty got=%b exp=1", if32.empty); end
    endtask

    task automatic test_hazard();
        do_reset();
        drive32(OPS, 3'b010, 32'd8, 32'h3000, 32'h5A5A5A5A, 1'b1, 1'b0, 32'd0);
        commit();
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h300A);
        total++; if (if32.hazard_hit !== 1'b1) begin bad++; $display("FAIL hz_same_word got=%b exp=1", if32.hazard_hit); end
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h300C);
        total++; if (if32.hazard_hit !== 1'b0) begin bad++; $display("FAIL hz_next_word got=%b exp=0", if32.hazard_hit); end
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h300A);
        commit();
        total++; if (if32.hazard_hit !== 1'b0) begin bad++; $display("FAIL hz_after_drain got=%b exp=0", if32.hazard_hit); end
        drive32(OPS, 3'b000, 32'd1, 32'h3010, 32'h77, 1'b1, 1'b0, 32'h3010);
        total++; if (if32.hazard_hit !== 1'b0) begin bad++; $display("FAIL hz_same_cycle got=%b exp=0", if32.hazard_hit); end
        commit();
        total++; if (if32.hazard_hit !== 1'b1) begin bad++; $display("FAIL hz_next_cycle got=%b exp=1", if32.hazard_hit); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive32(OPS, 3'b010, 32'd0, 32'h4000, 32'hA0, 1'b1, 1'b0, 32'd0);
        commit();
        drive32(OPS, 3'b010, 32'd0, 32'h4004, 32'hA1, 1'b1, 1'b0, 32'd0);
        commit();
        drive32(OPS, 3'b010, 32'd0, 32'h4008, 32'hA2, 1'b1, 1'b1, 32'd0);
        total++; if (if32.valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", if32.valid); end
        commit();
        total++; if ({if32.count, if32.mem_addr} !== {3'd2, 32'h4004}) begin
            bad++; $display("FAIL b2b_state got=%0d/%h exp=2/00004004", if32.count, if32.mem_addr); end
    endtask

    task automatic test_dw64();
        do_reset();
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive64(OPS, 3'b011, 32'd0, 32'h10, 64'h1122334455667788, 1'b1, 1'b0, 32'd0);
        total++; if ({if64.processing, if64.exception_valid_out} !== 2'b10) begin
            bad++; $display("FAIL sd_flags got=%b exp=10", {if64.processing, if64.exception_valid_out}); end
        commit();
        total++; if ({if64.mem_addr, if64.mem_data, if64.mem_strb} !== {32'h10, 64'h1122334455667788, 8'hFF}) begin
            bad++; $display("FAIL sd_entry got=%h/%h/%h exp=00000010/1122334455667788/ff", if64.mem_addr, if64.mem_data, if64.mem_strb); end
        drive64(OPS, 3'b011, 32'd0, 32'h14, 64'h1, 1'b1, 1'b0, 32'd0);
        total++; if (if64.exception_valid_out !== 1'b1) begin bad++; $display("FAIL sd_mis got=%b exp=1", if64.exception_valid_out); end
        commit();
        drive64(OPS, 3'b010, 32'd0, 32'h14, 64'hFFFFFFFF_CAFEBABE, 1'b1, 1'b0, 32'd0);
        commit();
        drive64(7'd0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b1, 32'd0);
        commit();
        total++; if ({if64.mem_addr, if64.mem_data, if64.mem_strb} !== {32'h10, 64'hCAFEBABE_00000000, 8'hF0}) begin
            bad++; $display("FAIL sw64_entry got=%h/%h/%h exp=00000010/cafebabe00000000/f0", if64.mem_addr, if64.mem_data, if64.mem_strb); end
        drive64(7'd0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 32'd0);
        drive32(OPS, 3'b011, 32'd0, 32'h10, 32'h1, 1'b1, 1'b0, 32'd0);
        total++; if ({if32.processing, if32.valid, if32.exception_valid_out} !== 3'b000) begin
            bad++; $display("FAIL sd_on32 got=%b exp=000", {if32.processing, if32.valid, if32.exception_valid_out}); end
        commit();
        for (int i = 0; i < 3; i++) begin
            drive32(OPS, 3'b010, 32'd0, 32'h6000 + 32'(4 * i), 32'(i), 1'b1, 1'b0, 32'd0);
            commit();
        end
        total++; if (if32.count !== 3'd3) begin bad++; $display("FAIL pend3_count got=%0d exp=3", if32.count); end
        reset_n = 1'b0;
        drive32(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        commit();
        reset_n = 1'b1;
        total++; if ({if32.empty, if32.mem_valid, if32.count} !== {1'b1, 1'b0, 3'd0}) begin
            bad++; $display("FAIL midrst got=%b/%b/%0d exp=1/0/0", if32.empty, if32.mem_valid, if32.count); end
    endtask

    task automatic test_random();
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] imm, rs1, rs2, haz, a, hz;
        logic        rv, rdy;
        bit          k, m, ehit;
        ent_t        hd;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            rv  = ($urandom_range(0, 9) != 0);
            opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPS;
            f3  = 3'($urandom_range(0, 4));
            rs1 = 32'h5000 + $urandom_range(0, 63);
            imm = ($urandom_range(0, 3) == 0) ? -32'($urandom_range(0, 15)) : 32'($urandom_range(0, 15));
            rs2 = $urandom;
            rdy = ($urandom_range(0, 2) == 0);
            if (q32.size() > 0 && $urandom_range(0, 1) == 1)
                haz = q32[$urandom_range(0, q32.size() - 1)].addr + $urandom_range(0, 3);
            else
                haz = 32'h4FF0 + $urandom_range(0, 127);
            drive32(opc, f3, imm, rs1, rs2, rv, rdy, haz);
            a = rs1 + imm;
            k = rv && m_known(opc, f3, 32);
            m = m_mis(f3, a);
            hd.addr = '0; hd.data = '0; hd.strb = '0;
            if (q32.size() > 0) hd = q32[0];
            hz = haz & ~32'h3;
            ehit = 1'b0;
            foreach (q32[i]) if (q32[i].addr == hz) ehit = 1'b1;
            total++; if (if32.processing !== k) begin bad++; $display("FAIL rnd_proc[%0d] got=%b exp=%b", c, if32.processing, k); end
            total++; if (if32.valid !== (k && (m || q32.size() < 4))) begin
                bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, if32.valid, (k && (m || q32.size() < 4))); end
            total++; if (if32.exception_valid_out !== (k && m)) begin
                bad++; $display("FAIL rnd_exc[%0d] got=%b exp=%b", c, if32.exception_valid_out, (k && m)); end
            total++; if (if32.exception_num_out !== 6'd6) begin bad++; $display("FAIL rnd_num[%0d] got=%0d exp=6", c, if32.exception_num_out); end
            total++; if (if32.mem_valid !== (q32.size() > 0)) begin
                bad++; $display("FAIL rnd_mvalid[%0d] got=%b exp=%b", c, if32.mem_valid, (q32.size() > 0)); end
            total++; if ({if32.mem_addr, if32.mem_data, if32.mem_strb} !== {hd.addr, hd.data[31:0], hd.strb[3:0]}) begin
                bad++; $display("FAIL rnd_head[%0d] got=%h/%h/%h exp=%h/%h/%h", c, if32.mem_addr, if32.mem_data,
                                if32.mem_strb, hd.addr, hd.data[31:0], hd.strb[3:0]); end
            total++; if ({if32.count, if32.empty} !== {3'(q32.size()), q32.size() == 0}) begin
                bad++; $display("FAIL rnd_count[%0d] got=%0d/%b exp=%0d", c, if32.count, if32.empty, q32.size()); end
            total++; if (if32.hazard_hit !== ehit) begin bad++; $display("FAIL rnd_hazard[%0d] got=%b exp=%b", c, if32.hazard_hit, ehit); end
            commit();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_misaligned();
        test_full_stall();
        test_hazard();
        test_back_to_back();
        test_dw64();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_store_queue.md
Name: execute_store_queue

Overview:
Parametrised successor to the single-cycle store execute stage. It decodes RISC-V store instructions, computes the effective address with an internal adder, and checks alignment. Aligned stores are converted into lane-aligned data/byte-strobe entries and placed in a DEPTH-entry FIFO store buffer. The buffer drains to the data memory port over a valid/ready handshake and exposes an address-match hazard check for the load unit.

Parameters:
DATA_W, 32, register/memory data width; 32 or 64 only; 64 enables SD (funct3 011)
ADDR_W, 32, address width
DEPTH, 4, store-buffer entries; power of two, >= 2

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
decode_opcode  in  7  opcode of instruction in execute
decode_funct3  in  3  funct3
decode_imm  in  ADDR_W  sign-extended S-immediate
read_rs1_val  in  ADDR_W  base register value
read_rs2_val  in  DATA_W  store data register value
read_valid  in  1  operands valid this cycle
processing  out  1  recognised store present
valid  out  1  store retired this cycle (enqueued or excepted)
exception_num_out  out  6  constant 6 (store address misaligned)
exception_valid_out  out  1  misaligned store this cycle
mem_addr  out  ADDR_W  head entry address, aligned to DATA_W/8 bytes
mem_data  out  DATA_W  head entry lane-positioned data
mem_strb  out  DATA_W/8  head entry byte enables
mem_valid  out  1  head entry valid
mem_ready  in  1  memory accepts head entry
hazard_addr  in  ADDR_W  load address to check
hazard_hit  out  1  pending entry covers hazard_addr's aligned word
count  out  $clog2(DEPTH+1)  occupied entries
empty  out  1  count == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n. While reset_n=0 at a clk edge: count=0, rd/wr pointers=0, all entries invalid. Consequently mem_valid=0, empty=1, hazard_hit=0, mem_addr/mem_data/mem_strb=0. Reset mid-drain discards all pending stores without handshake.
- Recognition: known = opcode==0100011 and funct3 in {000,001,010}, plus 011 when DATA_W==64. processing = read_valid && known (combinational).
- Address: addr = (read_rs1_val + decode_imm) mod 2^ADDR_W. off = addr[log2(DATA_W/8)-1:0].
- Misalignment:
  - half: addr[0]!=0
  - word: addr[1:0]!=0
  - double: addr[2:0]!=0
  - exception_valid_out = processing && misaligned
  - exception_num_out is always 6.
- Full and valid: full = (count==DEPTH), taken from the registered count; there is no same-cycle dequeue bypass. valid = processing && (misaligned || !full). When processing && !misaligned && full, valid=0 and the pipeline holds its inputs stable (stall).
- Enqueue:
  - Condition: processing && !misaligned && !full; write at wr_ptr, wr_ptr++ (wraps mod DEPTH).
  - Entry address: addr with low log2(DATA_W/8) bits cleared.
  - Entry data: rs2 truncated to the access size, shifted left by 8*off; unused bits 0.
  - Entry strobe: (1<<size_bytes)-1 shifted left by off.
  - Enqueued entry is visible on mem_* the next cycle (1-cycle latency).
- Drain:
  - mem_valid = !empty; mem_* present the rd_ptr entry and are zero when empty.
  - Dequeue on mem_valid && mem_ready; rd_ptr++ (wraps).
  - While mem_valid && !mem_ready, mem_* hold stable.
  - Entries retire strictly in order.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Full with dequeue: enqueue still blocked that cycle, accepted the next cycle.
- Hazard: hazard_hit = OR over occupied entries of (entry addr == hazard_addr with low bits cleared), combinational on registered state. An entry being enqueued in the same cycle is not included.
- Non-store or read_valid=0: processing=valid=exception_valid_out=0, no state change except drain.

Test Plan:
- Reset, DATA_W=32, rs1=0x1000, imm=0x3, rs2=0xAABBCCDD, SB -> next cycle mem_valid=1, mem_addr=0x1000, mem_data=0xDD000000, mem_strb=0b1000, count=1.
- SH to 0x1001 -> exception_valid_out=1, exception_num_out=6, valid=1, count unchanged, mem_valid stays 0.
- mem_ready=0, enqueue 5 SWs to 0x2000,0x2004,... -> first 4 accepted, 5th valid=0 (stall), count=4. Raise mem_ready for 1 cycle -> 0x2000 dequeued; stalled SW accepted the following cycle; order preserved on wrap.
- Enqueue SW to 0x3008 with mem_ready=0, hazard_addr=0x300A -> hazard_hit=1; hazard_addr=0x300C -> 0. After drain, hazard_hit=0.
- count=2, simultaneous enqueue and mem_ready=1 -> count stays 2, mem_addr advances to the second entry.
- DATA_W=64: SD to 0x10 -> mem_strb=0xFF. SD to 0x14 -> exception. funct3 011 with DATA_W=32 -> processing=0. Reset_n low with 3 entries pending -> next cycle empty=1, mem_valid=0.
